// File: rtl/rca_share_arbiter.sv
// Round-robin time-sharing of a single ripple-carry adder among NUM_REQ requesters.
// Operands and result are registered so the carry chain sits between register stages.
module rca_share_arbiter #(
    parameter int WIDTH   = 26,
    parameter int NUM_REQ = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_op1,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_op2,
    output logic [NUM_REQ-1:0]         o_rsp_valid,
    input  logic [NUM_REQ-1:0]         i_rsp_ready,
    output logic [WIDTH:0]             o_rsp_result,
    output logic                       o_busy
);
    localparam int IDXW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]   gnt_q, gnt_d;
    logic [IDXW-1:0]   pick_idx;
    logic              pick_found;
    logic              req_hs;
    logic              rsp_hs;
    logic [WIDTH-1:0]  op1_q, op1_d;
    logic [WIDTH-1:0]  op2_q, op2_d;
    logic [WIDTH-1:0]  add_sum;
    logic              add_cout;
    logic [WIDTH:0]    result_q, result_d;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && i_req_valid[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = IDXW'((int'(rr_ptr_q) + i) % NUM_REQ);
            end
        end
    end

    assign req_hs = (state_q == S_IDLE) && pick_found;
    assign rsp_hs = (state_q == S_RESP) && i_rsp_ready[gnt_q];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_hs) state_d = S_ADD;
            S_ADD:   state_d = S_RESP;
            S_RESP:  if (rsp_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready  = req_hs ? (NUM_REQ'(1) << pick_idx) : '0;
        o_rsp_valid  = (state_q == S_RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
        o_busy       = (state_q != S_IDLE);
        o_rsp_result = result_q;
    end

    always_comb begin
        op1_d    = op1_q;
        op2_d    = op2_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        result_d = result_q;
        if (req_hs) begin
            op1_d    = i_req_op1[pick_idx*WIDTH +: WIDTH];
            op2_d    = i_req_op2[pick_idx*WIDTH +: WIDTH];
            gnt_d    = pick_idx;
            rr_ptr_d = (pick_idx == IDXW'(NUM_REQ - 1)) ? '0 : pick_idx + IDXW'(1);
        end
        if (state_q == S_ADD) begin
            result_d = {add_cout, add_sum};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op1_q    <= '0;
            op2_q    <= '0;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            result_q <= '0;
        end else begin
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            result_q <= result_d;
        end
    end

    ripple_carry_adder_26bit #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i    (op1_q),
        .b_i    (op2_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );
endmodule

// Plain ripple-carry adder, carry-in tied low.
module ripple_carry_adder_26bit #(
    parameter int WIDTH = 26
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    logic carry;

    always_comb begin
        carry = 1'b0;
        sum_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end
endmodule

// File: tb/tb_rca_share_arbiter.sv
// Randomized bench for rca_share_arbiter against a transaction-level reference model.
module tb_rca_share_arbiter;
    localparam int WIDTH   = 26;
    localparam int NUM_REQ = 4;
    localparam logic [WIDTH-1:0] MAXOP = {WIDTH{1'b1}};

    logic                       i_clk;
    logic                       i_rst_n;
    logic [NUM_REQ-1:0]         i_req_valid;
    logic [NUM_REQ-1:0]         o_req_ready;
    logic [NUM_REQ*WIDTH-1:0]   i_req_op1;
    logic [NUM_REQ*WIDTH-1:0]   i_req_op2;
    logic [NUM_REQ-1:0]         o_rsp_valid;
    logic [NUM_REQ-1:0]         i_rsp_ready;
    logic [WIDTH:0]             o_rsp_result;
    logic                       o_busy;

    rca_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_op1    (i_req_op1),
        .i_req_op2    (i_req_op2),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_result (o_rsp_result),
        .o_busy       (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: transaction view of the shared adder.
    // m_cycles = cycles elapsed since the accepted request (0 = no transaction).
    int               m_cycles;
    int               m_ptr;
    int               m_gnt;
    int               m_acc;
    logic [WIDTH:0]   m_sum_pending;
    logic [WIDTH:0]   m_result;
    int               m_served [NUM_REQ];

    logic [WIDTH-1:0] rq_op1 [NUM_REQ];
    logic [WIDTH-1:0] rq_op2 [NUM_REQ];
    logic             rq_pend [NUM_REQ];

    function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++)
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic model_reset();
        m_cycles = 0;
        m_ptr    = 0;
        m_gnt    = 0;
        m_acc    = -1;
        m_result = '0;
        m_sum_pending = '0;
    endtask

    task automatic drive_reqs();
        for (int k = 0; k < NUM_REQ; k++) begin
            i_req_valid[k]               = rq_pend[k];
            i_req_op1[k*WIDTH +: WIDTH]  = rq_op1[k];
            i_req_op2[k*WIDTH +: WIDTH]  = rq_op2[k];
        end
    endtask

    // Called one time unit after a rising edge; checks at the falling edge, then advances.
    task automatic cycle();
        logic [NUM_REQ-1:0] exp_ready;
        logic [NUM_REQ-1:0] exp_rspv;
        int g;
        drive_reqs();
        #4;
        exp_ready = '0;
        exp_rspv  = '0;
        g = -1;
        m_acc = -1;
        if (m_cycles == 0) begin
            g = model_pick(i_req_valid, m_ptr);
            if (g >= 0) exp_ready[g] = 1'b1;
        end
        if (m_cycles >= 2) exp_rspv[m_gnt] = 1'b1;
        chk("req_ready", 64'(o_req_ready), 64'(exp_ready));
        chk("rsp_valid", 64'(o_rsp_valid), 64'(exp_rspv));
        chk("busy", 64'(o_busy), 64'(m_cycles != 0));
        chk("rsp_result", 64'(o_rsp_result), 64'(m_result));
        if (m_cycles == 0) begin
            if (g >= 0) begin
                m_gnt = g;
                m_acc = g;
                m_ptr = (g + 1) % NUM_REQ;
                m_sum_pending = {1'b0, rq_op1[g]} + {1'b0, rq_op2[g]};
                m_cycles = 1;
            end
        end else if (m_cycles == 1) begin
            m_result = m_sum_pending;
            m_cycles = 2;
        end else begin
            if (i_rsp_ready[m_gnt]) begin
                m_served[m_gnt]++;
                m_cycles = 0;
            end else begin
                m_cycles++;
            end
        end
        @(posedge i_clk);
        #1;
        if (m_acc >= 0) rq_pend[m_acc] = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] rand_op();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return MAXOP;
        if (sel == 1) return '0;
        return WIDTH'($urandom);
    endfunction

    initial begin
        i_rst_n     = 1'b0;
        i_req_valid = '0;
        i_rsp_ready = '0;
        i_req_op1   = '0;
        i_req_op2   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rq_op1[k] = '0; rq_op2[k] = '0; rq_pend[k] = 1'b0; m_served[k] = 0;
        end
        model_reset();
        #12;
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_rspv", 64'(o_rsp_valid), 64'd0);
        chk("rst_result", 64'(o_rsp_result), 64'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // Single add with full carry-out.
        rq_op1[0] = MAXOP; rq_op2[0] = 26'h0000001; rq_pend[0] = 1'b1;
        i_rsp_ready = '1;
        for (int c = 0; c < 4; c++) cycle();
        chk("single_add_result", 64'(o_rsp_result), 64'h4000000);

        // Round-robin with everybody valid continuously.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                rq_op1[k] = WIDTH'(k); rq_op2[k] = 26'h100; rq_pend[k] = 1'b1;
            end
            for (int c = 0; c < 3 * NUM_REQ; c++) cycle();
        end
        for (int k = 0; k < NUM_REQ; k++) rq_pend[k] = 1'b0;
        for (int c = 0; c < 4; c++) cycle();

        // Backpressure on requester 2 while other ready bits toggle.
        rq_op1[2] = 26'h1234567; rq_op2[2] = 26'h0FEDCBA; rq_pend[2] = 1'b1;
        i_rsp_ready = '0;
        for (int c = 0; c < 3; c++) cycle();
        rq_op1[0] = 26'h0000011; rq_op2[0] = 26'h0000022; rq_pend[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            i_rsp_ready = 4'b1011 & {2'b00, c[0], 1'b0} | 4'b1001;
            cycle();
        end
        chk("bp_result", 64'(o_rsp_result), 64'h2222221);
        i_rsp_ready = '1;
        for (int c = 0; c < 6; c++) cycle();

        // Async reset while requester 1's response is pending.
        rq_op1[1] = 26'h2AAAAAA; rq_op2[1] = 26'h1555556; rq_pend[1] = 1'b1;
        i_rsp_ready = '0;
        for (int c = 0; c < 10 && m_cycles < 2; c++) cycle();
        chk("pre_reset_rspv", 64'(o_rsp_valid), 64'b0010);
        for (int k = 0; k < NUM_REQ; k++) rq_pend[k] = 1'b0;
        drive_reqs();
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("mid_reset_rspv", 64'(o_rsp_valid), 64'd0);
        chk("mid_reset_busy", 64'(o_busy), 64'd0);
        chk("mid_reset_result", 64'(o_rsp_result), 64'd0);
        chk("mid_reset_ready", 64'(o_req_ready), 64'd0);
        model_reset();
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        i_rsp_ready = '1;
        rq_op1[1] = 26'h0000FFF; rq_op2[1] = 26'h0000001; rq_pend[1] = 1'b1;
        for (int c = 0; c < 5; c++) cycle();

        // Random traffic: requesters hold valid until served, operands scrambled afterwards.
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!rq_pend[k]) begin
                    rq_op1[k] = rand_op();
                    rq_op2[k] = rand_op();
                    if ($urandom_range(0, 3) == 0) rq_pend[k] = 1'b1;
                end
            end
            i_rsp_ready = NUM_REQ'($urandom);
            if ($urandom_range(0, 250) == 0) begin
                i_rst_n = 1'b0;
                #1;
                chk("rand_reset_busy", 64'(o_busy), 64'd0);
                model_reset();
                @(posedge i_clk); #1;
                i_rst_n = 1'b1;
            end
            cycle();
        end
        for (int k = 0; k < NUM_REQ; k++)
            if (m_served[k] == 0) chk("starved", 64'(m_served[k]), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
